// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter: edge-detected enter/exit events, saturating
// count with sticky error flag, and a two-digit seven-segment readout.
module parking_occupancy_counter #(
  parameter int CAPACITY = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       exit,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       err,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  localparam logic [4:0] CAP = 5'(CAPACITY);

  logic       r_enter_q;
  logic       r_exit_q;
  logic [4:0] r_count;
  logic       r_err;

  logic       w_enter_ev;
  logic       w_exit_ev;
  logic [4:0] w_count_nxt;
  logic       w_err_nxt;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_enter_ev = enter & ~r_enter_q;
  assign w_exit_ev  = exit  & ~r_exit_q;

  // Simultaneous enter and exit cancel out and leave both count and err alone.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    case ({w_enter_ev, w_exit_ev})
      2'b10: begin
        if (r_count < CAP) w_count_nxt = r_count + 5'd1;
        else               w_err_nxt   = 1'b1;
      end
      2'b01: begin
        if (r_count != 5'd0) w_count_nxt = r_count - 5'd1;
        else                 w_err_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Edge history resets high so an input already asserted at reset release is ignored.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_enter_q <= 1'b1;
      r_exit_q  <= 1'b1;
      r_count   <= 5'd0;
      r_err     <= 1'b0;
    end else begin
      r_enter_q <= enter;
      r_exit_q  <= exit;
      r_count   <= w_count_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign w_tens = 4'(r_count / 5'd10);
  assign w_ones = 4'(r_count % 5'd10);

  assign count = r_count;
  assign full  = (r_count == CAP);
  assign empty = (r_count == 5'd0);
  assign err   = r_err;
  assign hex1  = (w_tens == 4'd0) ? 7'b1111111 : seg7(w_tens);
  assign hex0  = seg7(w_ones);

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Scoreboard bench for parking_occupancy_counter: stimulus queues expected
// output snapshots tagged with the cycle they are due; a monitor checks them.
module tb_parking_occupancy_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic       exit;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       err;
  logic [6:0] hex1;
  logic [6:0] hex0;

  parking_occupancy_counter #(.CAPACITY(25)) dut (
    .clk   (clk),
    .reset (reset),
    .enter (enter),
    .exit  (exit),
    .count (count),
    .full  (full),
    .empty (empty),
    .err   (err),
    .hex1  (hex1),
    .hex0  (hex0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic [21:0] snap;   // {count, full, empty, err, hex1, hex0}
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  // Expected snapshot from hand-chosen count/err; flags and digits follow from count.
  task automatic expect_out(input string name, input int c, input bit e);
    exp_t x;
    logic [6:0] h1;
    h1 = (c / 10 == 0) ? 7'b1111111 : ref_seg(c / 10);
    x.due  = cyc + 1;
    x.name = name;
    x.snap = {5'(c), (c == 25), (c == 0), e, h1, ref_seg(c % 10)};
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t x;
      logic [21:0] got;
      x   = q.pop_front();
      got = {count, full, empty, err, hex1, hex0};
      n_checks++;
      if (got === x.snap) n_pass++;
      else
        $display("FAIL %s @cyc %0d: got count=%0d full=%b empty=%b err=%b hex1=%b hex0=%b, expected count=%0d full=%b empty=%b err=%b hex1=%b hex0=%b",
                 x.name, cyc, got[21:17], got[16], got[15], got[14], got[13:7], got[6:0],
                 x.snap[21:17], x.snap[16], x.snap[15], x.snap[14], x.snap[13:7], x.snap[6:0]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    expect_out("reset", 0, 1'b0);
    step(2);
    reset = 1'b0;
    step();
  endtask

  task automatic pulse_enter(input string name, input int c, input bit e);
    enter = 1'b1;
    expect_out(name, c, e);
    step();
    enter = 1'b0;
    step();
  endtask

  task automatic pulse_exit(input string name, input int c, input bit e);
    exit = 1'b1;
    expect_out(name, c, e);
    step();
    exit = 1'b0;
    step();
  endtask

  task automatic pulse_both(input string name, input int c, input bit e);
    enter = 1'b1;
    exit  = 1'b1;
    expect_out(name, c, e);
    step();
    enter = 1'b0;
    exit  = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    enter = 1'b0;
    exit  = 1'b0;
    step();

    // Basic counting, simultaneous events mid-range, decrement.
    do_reset();
    pulse_enter("enter1", 1, 1'b0);
    pulse_enter("enter2", 2, 1'b0);
    pulse_enter("enter3", 3, 1'b0);
    expect_out("hold3", 3, 1'b0);
    step();
    pulse_enter("enter4", 4, 1'b0);
    pulse_enter("enter5", 5, 1'b0);
    pulse_both("both_at5", 5, 1'b0);
    pulse_exit("exit_to4", 4, 1'b0);
    pulse_enter("enter_to5", 5, 1'b0);

    // Held input counts once; fill to capacity; overflow rejected.
    do_reset();
    enter = 1'b1;
    expect_out("held_first", 1, 1'b0);
    step(6);
    expect_out("held_mid", 1, 1'b0);
    step(4);
    enter = 1'b0;
    expect_out("held_release", 1, 1'b0);
    step();
    for (int i = 2; i <= 25; i++) pulse_enter($sformatf("fill%0d", i), i, 1'b0);
    pulse_both("both_at25", 25, 1'b0);
    pulse_enter("overflow", 25, 1'b1);
    pulse_exit("exit_after_ovf", 24, 1'b1);

    // Underflow rejected, sticky err, simultaneous at empty.
    do_reset();
    pulse_both("both_at0", 0, 1'b0);
    pulse_exit("underflow", 0, 1'b1);
    step(3);
    expect_out("err_sticky", 0, 1'b1);
    step();
    pulse_enter("enter_err_kept", 1, 1'b1);
    do_reset();

    // Enter already high at reset release is not an event.
    reset = 1'b1;
    enter = 1'b1;
    step(2);
    reset = 1'b0;
    expect_out("held_thru_reset", 0, 1'b0);
    step(3);
    expect_out("held_thru_reset2", 0, 1'b0);
    step();
    enter = 1'b0;
    step();
    pulse_enter("enter_after_low", 1, 1'b0);

    // Reset wins over an event in the same cycle.
    enter = 1'b1;
    reset = 1'b1;
    expect_out("reset_priority", 0, 1'b0);
    step();
    reset = 1'b0;
    enter = 1'b0;
    step(2);

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d expectations unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
